// File: rtl/rab_inv_engine.sv
// rab_inv_engine: one [min,max] request clears overlapping L1 slices, then walks the touched L2 TLB sets.
// Build option RAB_INV_L2_EN includes the L2 set walk; without it only the L1 slices are cleared.
module rab_inv_engine #(
    parameter int ADDR_WIDTH       = 32,
    parameter int N_SLICES         = 16,
    parameter int L2_N_SETS        = 32,
    parameter int L2_N_SET_ENTRIES = 32,
    parameter int PAGE_OFFSET      = 12,
    localparam int VW  = ADDR_WIDTH - PAGE_OFFSET,
    localparam int SW  = $clog2(L2_N_SETS),
    localparam int EW  = $clog2(L2_N_SET_ENTRIES),
    localparam int LAW = SW + EW
) (
    input  logic                           Clk_CI,
    input  logic                           Rst_RBI,
    input  logic [ADDR_WIDTH-1:0]          InvAddrMin_DI,
    input  logic [ADDR_WIDTH-1:0]          InvAddrMax_DI,
    input  logic                           InvValid_SI,
    output logic                           InvReady_SO,
    input  logic [N_SLICES*ADDR_WIDTH-1:0] L1AddrMin_DI,
    input  logic [N_SLICES*ADDR_WIDTH-1:0] L1AddrMax_DI,
    input  logic [N_SLICES-1:0]            L1En_SI,
    output logic [N_SLICES-1:0]            L1Clr_SO,
    output logic [LAW-1:0]                 L2RdAddr_DO,
    output logic                           L2Rd_SO,
    input  logic                           L2RdValid_DI,
    input  logic [VW-1:0]                  L2RdVpn_DI,
    output logic [LAW-1:0]                 L2WrAddr_DO,
    output logic                           L2Clr_SO,
    output logic                           Busy_SO,
    output logic                           Done_SO,
    output logic [15:0]                    InvCnt_DO
);
    localparam int VW1 = VW + 1;

    typedef enum logic [2:0] {IDLE, L1, L2_SCAN, L2_DRAIN, DONE} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] min_q, min_d, max_q, max_d;
    logic [15:0]           cnt_q, cnt_d, cnt_inc;
    logic [N_SLICES-1:0]   l1_hit;
    logic                  l2_clr;

    function automatic logic [15:0] popcount(input logic [N_SLICES-1:0] v);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < N_SLICES; i++) n = n + 16'(v[i]);
        return n;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_comb begin
        for (int i = 0; i < N_SLICES; i++) begin
            l1_hit[i] = L1En_SI[i]
                        && (L1AddrMin_DI[i*ADDR_WIDTH +: ADDR_WIDTH] <= max_q)
                        && (L1AddrMax_DI[i*ADDR_WIDTH +: ADDR_WIDTH] >= min_q);
        end
    end

`ifdef RAB_INV_L2_EN
    logic [SW-1:0]  set_q, set_d, sets_left_q, sets_left_d;
    logic [EW-1:0]  entry_q, entry_d;
    logic           rd_pend_q;
    logic [LAW-1:0] wr_addr_q;
    logic [VW-1:0]  vmin, vmax;
    logic [VW:0]    npages;

    // Page count is one bit wider so a range covering the whole address space does not wrap to 0.
    assign vmin        = min_q[ADDR_WIDTH-1:PAGE_OFFSET];
    assign vmax        = max_q[ADDR_WIDTH-1:PAGE_OFFSET];
    assign npages      = {1'b0, vmax} - {1'b0, vmin} + {{VW{1'b0}}, 1'b1};
    assign l2_clr      = rd_pend_q && L2RdValid_DI && (L2RdVpn_DI >= vmin) && (L2RdVpn_DI <= vmax);
    assign L2Rd_SO     = (state_q == L2_SCAN);
    assign L2RdAddr_DO = {set_q, entry_q};
    assign L2WrAddr_DO = wr_addr_q;
    assign L2Clr_SO    = l2_clr;

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            set_q       <= '0;
            sets_left_q <= '0;
            entry_q     <= '0;
            rd_pend_q   <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            set_q       <= set_d;
            sets_left_q <= sets_left_d;
            entry_q     <= entry_d;
            rd_pend_q   <= L2Rd_SO;
            wr_addr_q   <= L2RdAddr_DO;
        end
    end
`else
    logic unused_l2;
    assign unused_l2   = L2RdValid_DI ^ (^L2RdVpn_DI);
    assign l2_clr      = 1'b0;
    assign L2Rd_SO     = 1'b0;
    assign L2RdAddr_DO = '0;
    assign L2WrAddr_DO = '0;
    assign L2Clr_SO    = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        min_d    = min_q;
        max_d    = max_q;
        cnt_d    = cnt_q;
        cnt_inc  = '0;
        L1Clr_SO = '0;
`ifdef RAB_INV_L2_EN
        set_d       = set_q;
        sets_left_d = sets_left_q;
        entry_d     = entry_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (InvValid_SI) begin
                    min_d   = InvAddrMin_DI;
                    max_d   = InvAddrMax_DI;
                    cnt_d   = '0;
                    state_d = (InvAddrMin_DI > InvAddrMax_DI) ? DONE : L1;
                end
            end
            L1: begin
                L1Clr_SO = l1_hit;
                cnt_inc  = popcount(l1_hit);
`ifdef RAB_INV_L2_EN
                entry_d = '0;
                if (npages < VW1'(L2_N_SETS)) begin
                    set_d       = vmin[SW-1:0];
                    sets_left_d = SW'(npages - {{VW{1'b0}}, 1'b1});
                end else begin
                    set_d       = '0;
                    sets_left_d = '1;
                end
                state_d = L2_SCAN;
`else
                state_d = DONE;
`endif
            end
`ifdef RAB_INV_L2_EN
            L2_SCAN: begin
                entry_d = entry_q + 1'b1;
                if (entry_q == '1) begin
                    if (sets_left_q == '0) begin
                        state_d = L2_DRAIN;
                    end else begin
                        set_d       = set_q + 1'b1;
                        sets_left_d = sets_left_q - 1'b1;
                    end
                end
            end
            L2_DRAIN: state_d = DONE;
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cnt_inc = cnt_inc + 16'(l2_clr);
        if (cnt_inc != '0) cnt_d = sat_add(cnt_q, cnt_inc);
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q <= IDLE;
            min_q   <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
        end
    end

    assign InvReady_SO = (state_q == IDLE);
    assign Busy_SO     = ~InvReady_SO;
    assign Done_SO     = (state_q == DONE);
    assign InvCnt_DO   = cnt_q;

endmodule

// File: tb/tb_rab_inv_engine.sv
// tb_rab_inv_engine: directed vectors for rab_inv_engine against a small L2 TLB RAM model.
`timescale 1ns/1ps
module tb_rab_inv_engine;
    localparam int AW = 32, NS = 16, NSETS = 32, NENT = 32, VW = 20, LAW = 10;
`ifdef RAB_INV_L2_EN
    localparam bit L2 = 1'b1;
`else
    localparam bit L2 = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [AW-1:0]  inv_min = '0, inv_max = '0;
    logic           inv_valid = 1'b0, inv_ready;
    logic [NS*AW-1:0] l1_min = '0, l1_max = '0;
    logic [NS-1:0]  l1_en = '0, l1_clr;
    logic [LAW-1:0] rd_addr, wr_addr;
    logic           l2_rd, l2_clr, busy, done;
    logic           rd_vld = 1'b0;
    logic [VW-1:0]  rd_vpn = '0;
    logic [15:0]    cnt;

    always #5 clk = ~clk;

    rab_inv_engine dut (
        .Clk_CI(clk), .Rst_RBI(rst_n),
        .InvAddrMin_DI(inv_min), .InvAddrMax_DI(inv_max),
        .InvValid_SI(inv_valid), .InvReady_SO(inv_ready),
        .L1AddrMin_DI(l1_min), .L1AddrMax_DI(l1_max), .L1En_SI(l1_en), .L1Clr_SO(l1_clr),
        .L2RdAddr_DO(rd_addr), .L2Rd_SO(l2_rd), .L2RdValid_DI(rd_vld), .L2RdVpn_DI(rd_vpn),
        .L2WrAddr_DO(wr_addr), .L2Clr_SO(l2_clr),
        .Busy_SO(busy), .Done_SO(done), .InvCnt_DO(cnt)
    );

    // L2 TLB RAM model: registered read data, clears applied at the edge.
    logic          mem_v   [NSETS*NENT];
    logic [VW-1:0] mem_vpn [NSETS*NENT];
    int            fill_mode = 0;
    logic          poke_en = 1'b0;
    logic [LAW-1:0] poke_addr = '0;
    logic [VW-1:0] poke_vpn = '0;

    always @(posedge clk) begin
        rd_vld <= l2_rd ? mem_v[rd_addr] : 1'b0;
        rd_vpn <= mem_vpn[rd_addr];
        if (l2_clr) mem_v[wr_addr] <= 1'b0;
        if (fill_mode != 0) begin
            for (int a = 0; a < NSETS*NENT; a++) begin
                mem_v[a]   <= (fill_mode == 2);
                mem_vpn[a] <= VW'((a % NENT) * NSETS + a / NENT);
            end
        end
        if (poke_en) begin
            mem_v[poke_addr]   <= 1'b1;
            mem_vpn[poke_addr] <= poke_vpn;
        end
    end

    int errors = 0, checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int mode);
        @(negedge clk); fill_mode = mode;
        @(negedge clk); fill_mode = 0;
    endtask

    task automatic poke(input int addr, input logic [VW-1:0] vpn);
        @(negedge clk); poke_addr = LAW'(addr); poke_vpn = vpn; poke_en = 1'b1;
        @(negedge clk); poke_en = 1'b0;
    endtask

    task automatic set_slice(input int i, input logic [AW-1:0] mn, input logic [AW-1:0] mx);
        l1_min[i*AW +: AW] = mn;
        l1_max[i*AW +: AW] = mx;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_ready"},  32'(inv_ready), 1);
        check({pfx, "_busy"},   32'(busy), 0);
        check({pfx, "_done"},   32'(done), 0);
        check({pfx, "_l1clr"},  32'(l1_clr), 0);
        check({pfx, "_l2rd"},   32'(l2_rd), 0);
        check({pfx, "_l2clr"},  32'(l2_clr), 0);
        check({pfx, "_rdaddr"}, 32'(rd_addr), 0);
        check({pfx, "_wraddr"}, 32'(wr_addr), 0);
        check({pfx, "_cnt"},    32'(cnt), 0);
    endtask

    int            r_done, r_reads, r_clrs, r_watch_rd, r_watch_clr, watch_addr = -1;
    logic [NS-1:0] r_l1c1, r_l1any;
    logic [31:0]   r_sets;
    logic [15:0]   r_cnt, r_cnt_after;
    logic          r_ready_after, r_busy_c1;

    // Issue one request; cycle 1 is the first sample after the acceptance edge.
    task automatic run_req(input logic [AW-1:0] mn, input logic [AW-1:0] mx);
        @(negedge clk);
        check("ready_before_req", 32'(inv_ready), 1);
        inv_min = mn; inv_max = mx; inv_valid = 1'b1;
        r_done = -1; r_reads = 0; r_clrs = 0; r_watch_rd = -1; r_watch_clr = -1;
        r_l1any = '0; r_sets = '0; r_cnt = '0;
        @(negedge clk);
        inv_valid = 1'b0;
        r_l1c1 = l1_clr;
        r_busy_c1 = busy;
        for (int c = 1; c <= 1100; c++) begin
            if (c > 1) @(negedge clk);
            r_l1any |= l1_clr;
            if (l2_rd) begin
                r_reads++;
                r_sets[rd_addr[LAW-1:LAW-5]] = 1'b1;
                if (int'(rd_addr) == watch_addr) r_watch_rd = c;
            end
            if (l2_clr) begin
                r_clrs++;
                if (int'(wr_addr) == watch_addr) r_watch_clr = c;
            end
            if (done) begin
                r_done = c;
                r_cnt = cnt;
                break;
            end
        end
        @(negedge clk);
        r_ready_after = inv_ready;
        r_cnt_after = cnt;
    endtask

    function automatic int count_invalid();
        int n = 0;
        for (int a = 0; a < NSETS*NENT; a++) if (!mem_v[a]) n++;
        return n;
    endfunction

    initial begin
        int  abort_clrs;
        bit  hit;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        fill(1);

        // L1 hit on slice 3; disabled slice 4 with the same range stays untouched
        set_slice(3, 32'h20000, 32'h20FFF);
        set_slice(4, 32'h20000, 32'h20FFF);
        l1_en = 16'h0008;
        run_req(32'h20000, 32'h20FFF);
        check("l1hit_l1clr", 32'(r_l1c1), 32'h0008);
        check("l1hit_busy", 32'(r_busy_c1), 1);
        check("l1hit_done_cyc", r_done, L2 ? 35 : 2);
        check("l1hit_reads", r_reads, L2 ? 32 : 0);
        check("l1hit_sets", r_sets, L2 ? 32'h1 : 32'h0);
        check("l1hit_cnt", 32'(r_cnt), 1);
        check("l1hit_ready_after", 32'(r_ready_after), 1);
        check("l1hit_cnt_hold", 32'(r_cnt_after), 1);

        // L1 boundaries: touching at max/min hits, adjacent slices do not
        set_slice(2, 32'h1F000, 32'h1FFFF);
        set_slice(5, 32'h20FFF, 32'h30000);
        set_slice(6, 32'h10000, 32'h20000);
        set_slice(7, 32'h21000, 32'h21FFF);
        l1_en = 16'h00EC;
        run_req(32'h20000, 32'h20FFF);
        check("l1edge_l1clr", 32'(r_l1c1), 32'h0068);
        check("l1edge_cnt", 32'(r_cnt), 3);
        l1_en = '0;

        // Single L2 page in set 5; a set-5 entry outside the range is kept
        fill(1);
        poke(162, 20'h25);
        poke(163, 20'h45);
        watch_addr = 162;
        run_req(32'h25000, 32'h25FFF);
        check("page_reads", r_reads, L2 ? 32 : 0);
        check("page_sets", r_sets, L2 ? 32'h20 : 32'h0);
        check("page_clrs", r_clrs, L2 ? 1 : 0);
        check("page_rd_cyc", r_watch_rd, L2 ? 4 : -1);
        check("page_clr_cyc", r_watch_clr, L2 ? 5 : -1);
        check("page_done_cyc", r_done, L2 ? 35 : 2);
        check("page_cnt", 32'(r_cnt), L2 ? 1 : 0);
        check("page_mem162", 32'(mem_v[162]), L2 ? 0 : 1);
        check("page_mem163", 32'(mem_v[163]), 1);

        // Set list wrapping 30,31,0,1
        fill(1);
        poke(960, 20'h3E);
        poke(992, 20'h5F);
        poke(7, 20'h40);
        poke(64, 20'h42);
        watch_addr = 7;
        run_req(32'h3E000, 32'h41FFF);
        check("wrap_reads", r_reads, L2 ? 128 : 0);
        check("wrap_sets", r_sets, L2 ? 32'hC000_0003 : 32'h0);
        check("wrap_done_cyc", r_done, L2 ? 131 : 2);
        check("wrap_clrs", r_clrs, L2 ? 2 : 0);
        check("wrap_rd_cyc", r_watch_rd, L2 ? 73 : -1);
        check("wrap_clr_cyc", r_watch_clr, L2 ? 74 : -1);
        check("wrap_cnt", 32'(r_cnt), L2 ? 2 : 0);
        check("wrap_mem64", 32'(mem_v[64]), 1);
        check("wrap_mem992", 32'(mem_v[992]), 1);

        // Empty range with an overlapping enabled slice
        set_slice(3, 32'h1000, 32'h2000);
        l1_en = 16'h0008;
        watch_addr = -1;
        run_req(32'h2000, 32'h1000);
        check("empty_done_cyc", r_done, 1);
        check("empty_l1any", 32'(r_l1any), 0);
        check("empty_clrs", r_clrs, 0);
        check("empty_cnt", 32'(r_cnt), 0);
        check("empty_ready_after", 32'(r_ready_after), 1);
        l1_en = '0;

        // Top page of the address space
        fill(1);
        poke(996, 20'hFFFFF);
        poke(997, 20'h0);
        run_req(32'hFFFF_F000, 32'hFFFF_FFFF);
        check("top_sets", r_sets, L2 ? 32'h8000_0000 : 32'h0);
        check("top_clrs", r_clrs, L2 ? 1 : 0);
        check("top_cnt", 32'(r_cnt), L2 ? 1 : 0);
        check("top_done_cyc", r_done, L2 ? 35 : 2);
        check("top_mem996", 32'(mem_v[996]), L2 ? 0 : 1);
        check("top_mem997", 32'(mem_v[997]), 1);

        // Full sweep over 1024 pages, every entry valid
        fill(2);
        run_req(32'h0, 32'h3F_FFFF);
        check("sweep_reads", r_reads, L2 ? 1024 : 0);
        check("sweep_sets", r_sets, L2 ? 32'hFFFF_FFFF : 32'h0);
        check("sweep_clrs", r_clrs, L2 ? 1024 : 0);
        check("sweep_done_cyc", r_done, L2 ? 1027 : 2);
        check("sweep_cnt", 32'(r_cnt), L2 ? 1024 : 0);
        check("sweep_cnt_hold", 32'(r_cnt_after), L2 ? 1024 : 0);
        check("sweep_invalid", count_invalid(), L2 ? 1024 : 0);

        // Whole address space must not wrap the page count
        fill(1);
        run_req(32'h0, 32'hFFFF_FFFF);
        check("fullrange_reads", r_reads, L2 ? 1024 : 0);
        check("fullrange_done_cyc", r_done, L2 ? 1027 : 2);
        check("fullrange_cnt", 32'(r_cnt), 0);

        // Reset during the set-3 scan of a full sweep
        fill(2);
        @(negedge clk);
        inv_min = 32'h0; inv_max = 32'h3F_FFFF; inv_valid = 1'b1;
        @(negedge clk);
        inv_valid = 1'b0;
        hit = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            if (c > 1) @(negedge clk);
            if (L2 ? (l2_rd && rd_addr == LAW'(3*32 + 10)) : (c == 1)) begin
                hit = 1'b1;
                break;
            end
        end
        check("abort_trigger", 32'(hit), 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_vals("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        abort_clrs = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (l2_clr) abort_clrs++;
        end
        check("abort_no_clr", abort_clrs, 0);
        check("abort_cleared", count_invalid(), L2 ? 106 : 0);

        run_req(32'h2000, 32'h1000);
        check("post_abort_done_cyc", r_done, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
